// File: rtl/task_mapper_pkg.sv
// Shared types and mesh geometry helpers for the greedy task-to-PE mapper.
// PE p sits at x = p % mesh_x, y = p / mesh_x.
package task_mapper_pkg;

  localparam int DEF_NUM_V  = 4;
  localparam int DEF_W      = 32;
  localparam int DEF_IDX_W  = 32;
  localparam int DEF_MESH_X = 2;
  localparam int DEF_MESH_Y = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEL,
    S_PLACE,
    S_COST,
    S_DONE
  } state_t;

  function automatic int pe_x(input int p, input int mesh_x);
    return p % mesh_x;
  endfunction

  function automatic int pe_y(input int p, input int mesh_x);
    return p / mesh_x;
  endfunction

  function automatic int hops(input int a, input int b, input int mesh_x);
    int dx;
    int dy;
    dx = pe_x(a, mesh_x) - pe_x(b, mesh_x);
    dy = pe_y(a, mesh_x) - pe_y(b, mesh_x);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return dx + dy;
  endfunction

endpackage

// File: rtl/tm_place_cost.sv
// Combinational placement cost of one candidate task on every PE, plus argmin over free PEs.
// Ties resolve to the lowest PE id.
module tm_place_cost
  import task_mapper_pkg::*;
#(
  parameter int NUM_V  = DEF_NUM_V,
  parameter int W      = DEF_W,
  parameter int MESH_X = DEF_MESH_X,
  parameter int COST_W = DEF_W + 8,
  parameter int PW     = $clog2(DEF_NUM_V)
) (
  input  logic [NUM_V-1:0][NUM_V-1:0][W-1:0] mat,
  input  logic [PW-1:0]                      cand,
  input  logic [NUM_V-1:0][PW-1:0]           pe_of,
  input  logic [NUM_V-1:0]                   mapped,
  input  logic [NUM_V-1:0]                   used,
  output logic [PW-1:0]                      best_pe
);

  logic [NUM_V-1:0][COST_W-1:0] cost;
  logic [COST_W-1:0]            best_cost;
  logic                         found;

  always_comb begin
    cost = '0;
    for (int q = 0; q < NUM_V; q++) begin
      for (int m = 0; m < NUM_V; m++) begin
        if (mapped[m]) begin
          cost[q] = cost[q] +
                    (COST_W'(mat[cand][m]) + COST_W'(mat[m][cand])) *
                    COST_W'(hops(q, int'(pe_of[m]), MESH_X));
        end
      end
    end
  end

  always_comb begin
    best_pe   = '0;
    best_cost = '0;
    found     = 1'b0;
    for (int q = 0; q < NUM_V; q++) begin
      if (!used[q] && (!found || cost[q] < best_cost)) begin
        found     = 1'b1;
        best_cost = cost[q];
        best_pe   = PW'(q);
      end
    end
  end

endmodule

// File: rtl/task_mapper.sv
// Captures a streamed task-graph adjacency matrix and greedily maps tasks onto a 2-D mesh.
// Map valid 2*(NUM_V-1)+1 cycles after the last element; no backpressure, loader paces the stream.
module task_mapper
  import task_mapper_pkg::*;
#(
  parameter int NUM_V  = DEF_NUM_V,
  parameter int W      = DEF_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int MESH_X = DEF_MESH_X,
  parameter int MESH_Y = DEF_MESH_Y
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [W-1:0]                  task_array,
  input  logic                          root_task,
  input  logic [IDX_W-1:0]              row,
  input  logic [IDX_W-1:0]              col,
  output logic [NUM_V*$clog2(NUM_V)-1:0] task_pe,
  output logic                          map_valid,
  output logic                          busy,
  output logic [W+7:0]                  total_cost
);

  localparam int PW     = $clog2(NUM_V);
  localparam int CONN_W = W + $clog2(2 * NUM_V);
  localparam int COST_W = W + 8;

  state_t                            state;
  logic [NUM_V-1:0][NUM_V-1:0][W-1:0] mat;
  logic [NUM_V-1:0][PW-1:0]          pe_of;
  logic [NUM_V-1:0]                  mapped;
  logic [NUM_V-1:0]                  used;
  logic [PW-1:0]                     root;
  logic [PW-1:0]                     sel_task;
  logic [PW-1:0]                     pick;
  logic [PW-1:0]                     best_pe;
  logic [PW-1:0]                     r_idx;
  logic [PW-1:0]                     c_idx;
  logic                              in_range;
  logic                              is_last;
  logic                              wr_en;
  logic [CONN_W-1:0]                 conn;
  logic [CONN_W-1:0]                 best_conn;
  logic                              found;
  logic [COST_W-1:0]                 cost_sum;

  // Indices arrive as signed ints: negative values have the MSB set.
  assign in_range = !row[IDX_W-1] && !col[IDX_W-1] &&
                    (row < IDX_W'(NUM_V)) && (col < IDX_W'(NUM_V));
  assign r_idx    = row[PW-1:0];
  assign c_idx    = col[PW-1:0];
  assign is_last  = in_range && (row == IDX_W'(NUM_V - 1)) && (col == IDX_W'(NUM_V - 1));
  assign wr_en    = in_range && (task_array != '0);
  assign task_pe  = pe_of;

  always_comb begin
    pick      = '0;
    best_conn = '0;
    found     = 1'b0;
    conn      = '0;
    for (int t = 0; t < NUM_V; t++) begin
      conn = '0;
      for (int m = 0; m < NUM_V; m++) begin
        if (mapped[m]) conn = conn + CONN_W'(mat[t][m]) + CONN_W'(mat[m][t]);
      end
      if (!mapped[t] && (!found || conn > best_conn)) begin
        found     = 1'b1;
        best_conn = conn;
        pick      = PW'(t);
      end
    end
  end

  always_comb begin
    cost_sum = '0;
    for (int a = 0; a < NUM_V; a++) begin
      for (int b = 0; b < NUM_V; b++) begin
        cost_sum = cost_sum + COST_W'(mat[a][b]) *
                   COST_W'(hops(int'(pe_of[a]), int'(pe_of[b]), MESH_X));
      end
    end
  end

  tm_place_cost #(
    .NUM_V  (NUM_V),
    .W      (W),
    .MESH_X (MESH_X),
    .COST_W (COST_W),
    .PW     (PW)
  ) u_place_cost (
    .mat     (mat),
    .cand    (sel_task),
    .pe_of   (pe_of),
    .mapped  (mapped),
    .used    (used),
    .best_pe (best_pe)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      mat        <= '0;
      pe_of      <= '0;
      mapped     <= '0;
      used       <= '0;
      root       <= '0;
      sel_task   <= '0;
      map_valid  <= 1'b0;
      busy       <= 1'b0;
      total_cost <= '0;
    end else if (root_task) begin
      mat <= '0;
      if (wr_en) mat[r_idx][c_idx] <= task_array;
      root      <= r_idx;
      pe_of     <= '0;
      mapped    <= '0;
      used      <= '0;
      map_valid <= 1'b0;
      busy      <= 1'b0;
      state     <= S_CAPTURE;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (wr_en) mat[r_idx][c_idx] <= task_array;
          if (is_last) begin
            // Root anchors the mapping on PE0.
            pe_of[root] <= '0;
            mapped      <= NUM_V'(1) << root;
            used        <= NUM_V'(1);
            busy        <= 1'b1;
            state       <= S_SEL;
          end
        end
        S_SEL: begin
          sel_task <= pick;
          state    <= S_PLACE;
        end
        S_PLACE: begin
          pe_of[sel_task]  <= best_pe;
          mapped[sel_task] <= 1'b1;
          used[best_pe]    <= 1'b1;
          if ((mapped | (NUM_V'(1) << sel_task)) == '1) state <= S_COST;
          else state <= S_SEL;
        end
        S_COST: begin
          total_cost <= cost_sum;
          map_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= S_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_task_mapper.sv
// Directed bench for task_mapper: two graphs, held elements, no-root stream, reset abort, bad indices.
module tb_task_mapper;

  logic        clk;
  logic        rst_b;
  logic [31:0] task_array;
  logic        root_task;
  logic [31:0] row;
  logic [31:0] col;
  logic [7:0]  task_pe;
  logic        map_valid;
  logic        busy;
  logic [39:0] total_cost;

  logic [31:0] g [4][4];
  int          errors;
  int          checks;

  task_mapper dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .task_array (task_array),
    .root_task  (root_task),
    .row        (row),
    .col        (col),
    .task_pe    (task_pe),
    .map_valid  (map_valid),
    .busy       (busy),
    .total_cost (total_cost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    task_array = '0;
    root_task  = 1'b0;
    row        = 32'hFFFF_FFFF;
    col        = 32'hFFFF_FFFF;
  endtask

  task automatic drive(input int r, input int c, input logic [31:0] w, input bit rt, input int n);
    row        = r;
    col        = c;
    task_array = w;
    root_task  = rt;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_graph1();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) g[i][j] = '0;
    g[0][1] = 5; g[1][0] = 5;
    g[0][3] = 7; g[3][0] = 7;
    g[1][2] = 6; g[2][1] = 6;
  endtask

  task automatic load_graph2();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) g[i][j] = '0;
    g[2][3] = 9; g[3][2] = 9;
  endtask

  // Streams g row-major, checks latency and result; abort pulses reset while in PLACE.
  task automatic stream(input string tag, input int r0, input int c0, input int hold,
                        input bit use_root, input bit bad, input bit abort,
                        input logic [7:0] exp_pe, input logic [39:0] exp_cost);
    if (use_root) begin
      drive(r0, c0, g[r0][c0], 1'b1, hold);
      chk({tag, "_mv_drop"}, 64'(map_valid), 64'd0);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (bad) begin
          drive(4, c, 32'd99, 1'b0, 1);
          drive(r, -1, 32'd99, 1'b0, 1);
        end
        if (!(r == 3 && c == 3)) drive(r, c, g[r][c], 1'b0, hold);
      end
    end
    drive(3, 3, g[3][3], 1'b0, 1);
    if (!use_root) begin
      set_idle();
      repeat (10) @(posedge clk);
      #1;
      chk({tag, "_mv"}, 64'(map_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_pe"}, 64'(task_pe), 64'd0);
      return;
    end
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    if (hold == 1) set_idle();
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        set_idle();
        if (abort) begin
          rst_b = 1'b0;
          #1;
          chk({tag, "_rst_pe"}, 64'(task_pe), 64'd0);
          chk({tag, "_rst_mv"}, 64'(map_valid), 64'd0);
          chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
          chk({tag, "_rst_cost"}, 64'(total_cost), 64'd0);
          @(negedge clk);
          rst_b = 1'b1;
          @(posedge clk);
          #1;
          return;
        end
      end
      if (n == 6) chk({tag, "_mv_k6"}, 64'(map_valid), 64'd0);
      if (n == 7) chk({tag, "_mv_k7"}, 64'(map_valid), 64'd1);
    end
    chk({tag, "_pe"}, 64'(task_pe), 64'(exp_pe));
    chk({tag, "_cost"}, 64'(total_cost), 64'(exp_cost));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold"}, 64'(map_valid), 64'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_b  = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pe", 64'(task_pe), 64'd0);
    chk("rst_mv", 64'(map_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cost", 64'(total_cost), 64'd0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    load_graph1();
    stream("noroot", 0, 1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 40'd0);
    // t0->PE0, t1->PE2, t2->PE3, t3->PE1
    stream("g1", 0, 1, 1, 1'b1, 1'b0, 1'b0, 8'h78, 40'd36);
    stream("g1_hold2", 0, 1, 2, 1'b1, 1'b0, 1'b0, 8'h78, 40'd36);

    // t2->PE0, t3->PE1, t0->PE2, t1->PE3
    load_graph2();
    stream("g2", 2, 3, 1, 1'b1, 1'b0, 1'b0, 8'h4E, 40'd18);

    load_graph1();
    stream("abort", 0, 1, 1, 1'b1, 1'b0, 1'b1, 8'h00, 40'd0);
    stream("g1_again", 0, 1, 1, 1'b1, 1'b0, 1'b0, 8'h78, 40'd36);
    stream("g1_bad", 0, 1, 1, 1'b1, 1'b1, 1'b0, 8'h78, 40'd36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
